mtx_hop_scheduler: RTL and testbench



---
 rtl/mtx_hop_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_mtx_hop_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtx_hop_scheduler.sv
// Hop sequencer for the mtx_sig_tag_chip tone generator.
// Optional statistics counters: define MTX_HOP_SCHED_STATS_EN.
module mtx_hop_scheduler #(
  parameter int PHASE_WIDTH = 24,
  parameter int HOP_ADDR_W  = 4,
  parameter int STAT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_wr_en,
  input  logic [HOP_ADDR_W-1:0]  cfg_wr_addr,
  input  logic [PHASE_WIDTH-1:0] cfg_wr_data,
  output logic                   cfg_wr_err,
  input  logic [HOP_ADDR_W:0]    num_hops,
  input  logic                   loop_en,
  input  logic                   start,
  input  logic                   stop,
  output logic                   busy,
  output logic                   done,
  output logic                   frame_done,
  output logic [HOP_ADDR_W-1:0]  cur_hop,
  output logic                   chip_srst,
  output logic                   chip_phase_tvalid,
  output logic                   chip_phase_tlast,
  output logic [PHASE_WIDTH-1:0] chip_hop_phase_inc,
  input  logic                   chip_phase_tready,
  input  logic                   chip_hop_ready
`ifdef MTX_HOP_SCHED_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]  stat_hops,
  output logic [STAT_WIDTH-1:0]  stat_frames,
  output logic [STAT_WIDTH-1:0]  stat_stall
`endif
);

  localparam int DEPTH = 1 << HOP_ADDR_W;

  localparam logic [HOP_ADDR_W:0]   NH_ONE  = 1;
  localparam logic [HOP_ADDR_W-1:0] HOP_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_STOP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [PHASE_WIDTH-1:0] hop_tbl [DEPTH];

  logic [HOP_ADDR_W:0]   nh_q;
  logic                  loop_q;
  logic [HOP_ADDR_W-1:0] nxt_q;
  logic [HOP_ADDR_W-1:0] nxt_wrap;
  logic [HOP_ADDR_W-1:0] load_nxt;
  logic [HOP_ADDR_W:0]   last_hop;

  logic start_ok;
  logic running;
  logic boundary;
  logic frame_end;

  assign start_ok = start && (num_hops != '0);
  assign running  = (state_q == S_RUN) ||
                    (state_q == S_STOP);
  assign boundary = running && chip_hop_ready;
  assign last_hop = nh_q - NH_ONE;

  assign frame_end = boundary &&
    ({1'b0, cur_hop} == last_hop);

  // Successor of the pending hop, wrapping at the frame length
  assign nxt_wrap =
    (({1'b0, nxt_q} + NH_ONE) == nh_q) ?
    '0 : nxt_q + HOP_ONE;

  assign load_nxt = (nh_q == NH_ONE) ?
    '0 : HOP_ONE;

  always_ff @(posedge clk) begin
    if (cfg_wr_en && (state_q == S_IDLE)) begin
      hop_tbl[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (frame_end && !loop_q) begin
          state_d = S_IDLE;
        end else if (stop) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (chip_hop_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy              = (state_q != S_IDLE);
    chip_srst         = (state_q == S_IDLE) ||
                        (state_q == S_LOAD);
    chip_phase_tvalid = running;
    frame_done        = frame_end;
    chip_phase_tlast  = frame_end ||
      ((state_q == S_STOP) && chip_hop_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nh_q               <= '0;
      loop_q             <= 1'b0;
      nxt_q              <= '0;
      cur_hop            <= '0;
      chip_hop_phase_inc <= '0;
      done               <= 1'b0;
      cfg_wr_err         <= 1'b0;
    end else begin
      done       <= (state_q != S_IDLE) &&
                    (state_d == S_IDLE);
      cfg_wr_err <= cfg_wr_en &&
                    (state_q != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          chip_hop_phase_inc <= hop_tbl[0];
          if (start_ok) begin
            nh_q   <= num_hops;
            loop_q <= loop_en;
          end
        end
        S_LOAD: begin
          cur_hop            <= '0;
          nxt_q              <= load_nxt;
          chip_hop_phase_inc <= hop_tbl[load_nxt];
        end
        S_RUN, S_STOP: begin
          // Generator has just latched the pending hop
          if (chip_hop_ready) begin
            cur_hop            <= nxt_q;
            nxt_q              <= nxt_wrap;
            chip_hop_phase_inc <= hop_tbl[nxt_wrap];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MTX_HOP_SCHED_STATS_EN
  logic stat_clr;

  assign stat_clr = reset ||
    ((state_q == S_IDLE) && start_ok);

  always_ff @(posedge clk) begin
    if (stat_clr) begin
      stat_hops   <= '0;
      stat_frames <= '0;
      stat_stall  <= '0;
    end else begin
      if (boundary && (stat_hops != '1)) begin
        stat_hops <= stat_hops + 1'b1;
      end
      if (frame_done && (stat_frames != '1)) begin
        stat_frames <= stat_frames + 1'b1;
      end
      if (chip_phase_tvalid && !chip_phase_tready &&
          (stat_stall != '1)) begin
        stat_stall <= stat_stall + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mtx_hop_scheduler.sv
// Randomized bench for mtx_hop_scheduler against a hop-count model.
// Stats checks compile in with MTX_HOP_SCHED_STATS_EN.
module tb_mtx_hop_scheduler;

  localparam int PW = 24;
  localparam int AW = 4;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_wr_en = 1'b0;
  logic [AW-1:0] cfg_wr_addr = '0;
  logic [PW-1:0] cfg_wr_data = '0;
  logic          cfg_wr_err;
  logic [AW:0]   num_hops = '0;
  logic          loop_en = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          busy;
  logic          done;
  logic          frame_done;
  logic [AW-1:0] cur_hop;
  logic          chip_srst;
  logic          chip_phase_tvalid;
  logic          chip_phase_tlast;
  logic [PW-1:0] chip_hop_phase_inc;
  logic          chip_phase_tready = 1'b1;
  logic          chip_hop_ready = 1'b0;
`ifdef MTX_HOP_SCHED_STATS_EN
  logic [SW-1:0] stat_hops;
  logic [SW-1:0] stat_frames;
  logic [SW-1:0] stat_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [PW-1:0] tbl_m [16];

  always #5 clk = ~clk;

  mtx_hop_scheduler #(
    .PHASE_WIDTH(PW),
    .HOP_ADDR_W (AW),
    .STAT_WIDTH (SW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .cfg_wr_en         (cfg_wr_en),
    .cfg_wr_addr       (cfg_wr_addr),
    .cfg_wr_data       (cfg_wr_data),
    .cfg_wr_err        (cfg_wr_err),
    .num_hops          (num_hops),
    .loop_en           (loop_en),
    .start             (start),
    .stop              (stop),
    .busy              (busy),
    .done              (done),
    .frame_done        (frame_done),
    .cur_hop           (cur_hop),
    .chip_srst         (chip_srst),
    .chip_phase_tvalid (chip_phase_tvalid),
    .chip_phase_tlast  (chip_phase_tlast),
    .chip_hop_phase_inc(chip_hop_phase_inc),
    .chip_phase_tready (chip_phase_tready),
    .chip_hop_ready    (chip_hop_ready)
`ifdef MTX_HOP_SCHED_STATS_EN
    ,
    .stat_hops         (stat_hops),
    .stat_frames       (stat_frames),
    .stat_stall        (stat_stall)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_srst"}, chip_srst, 1);
    chk({tag, "_tvalid"}, chip_phase_tvalid, 0);
    chk({tag, "_tlast"}, chip_phase_tlast, 0);
    chk({tag, "_inc"}, chip_hop_phase_inc, 0);
    chk({tag, "_cur"}, cur_hop, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fdone"}, frame_done, 0);
    chk({tag, "_wrerr"}, cfg_wr_err, 0);
  endtask

  task automatic tbl_write(input int a,
                           input logic [PW-1:0] d);
    @(negedge clk);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = AW'(a);
    cfg_wr_data = d;
    @(negedge clk);
    cfg_wr_en = 1'b0;
    #1;
    chk("wr_err_idle", cfg_wr_err, 0);
    tbl_m[a] = d;
  endtask

  // One generator session: hops of fixed length, optional
  // stop request at (stop_k, stop_c), optional write probe.
  task automatic run(input int nh, input bit lp,
                     input int len, input int stop_k,
                     input int stop_c, input bit stop_at_start,
                     input bit wr_probe);
    int  k;
    bit  pend;
    bit  fin;
    bit  fe;
    bit  st;
    bit  rdy;
    @(negedge clk);
    start    = 1'b1;
    num_hops = (AW+1)'(nh);
    loop_en  = lp;
    stop     = stop_at_start;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_srst", chip_srst, 1);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    #1;
    chk("load_busy", busy, 1);
    chk("load_srst", chip_srst, 1);
    chk("load_tvalid", chip_phase_tvalid, 0);
    chk("load_inc", chip_hop_phase_inc, tbl_m[0]);
    k    = 0;
    pend = 1'b0;
    fin  = 1'b0;
    while (!fin) begin
      for (int c = 0; c < len && !fin; c++) begin
        @(negedge clk);
        rdy = (c == len - 1);
        st  = (k == stop_k) && (c == stop_c);
        chip_hop_ready    = rdy;
        stop              = st;
        chip_phase_tready = ($urandom_range(0, 3) != 0);
        cfg_wr_en   = wr_probe && (k == 0) && (c == 0);
        cfg_wr_addr = '0;
        cfg_wr_data = ~tbl_m[0];
        #1;
        fe = rdy && ((k % nh) == nh - 1);
        chk("run_srst", chip_srst, 0);
        chk("run_tvalid", chip_phase_tvalid, 1);
        chk("run_busy", busy, 1);
        chk("run_cur", cur_hop, k % nh);
        chk("run_inc", chip_hop_phase_inc,
            tbl_m[(k + 1) % nh]);
        chk("run_tlast", chip_phase_tlast,
            rdy && (fe || pend));
        chk("run_fdone", frame_done, fe);
        chk("run_wrerr", cfg_wr_err,
            wr_probe && (k == 0) && (c == 1));
        if (rdy) begin
          if (pend || (fe && !lp)) begin
            fin = 1'b1;
          end else if (st) begin
            pend = 1'b1;
          end
          k++;
        end else if (st) begin
          pend = 1'b1;
        end
      end
    end
    @(negedge clk);
    chip_hop_ready = 1'b0;
    stop           = 1'b0;
    cfg_wr_en      = 1'b0;
    #1;
    chk("end_done", done, 1);
    chk("end_srst", chip_srst, 1);
    chk("end_busy", busy, 0);
    chk("end_tvalid", chip_phase_tvalid, 0);
    chk("end_tlast", chip_phase_tlast, 0);
    @(negedge clk);
    #1;
    chk("end_done_pulse", done, 0);
    chk("idle_inc", chip_hop_phase_inc, tbl_m[0]);
  endtask

  initial begin
    int nh;
    int len;
    int sk;
    int sc;
    bit lp;

    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      tbl_write(i, PW'($urandom));
    end
    tbl_write(0, 24'h001000);
    tbl_write(1, 24'h002000);
    tbl_write(2, 24'h003000);

    // one-shot, loop, graceful stop
    run(3, 1'b0, 8, -1, 0, 1'b0, 1'b0);
    run(2, 1'b1, 6, 4, 2, 1'b0, 1'b0);
    run(4, 1'b0, 8, 1, 3, 1'b0, 1'b0);

    // write guard, then accepted write in IDLE
    run(3, 1'b0, 4, -1, 0, 1'b0, 1'b1);
    tbl_write(0, 24'h0abcde);
    run(2, 1'b0, 3, -1, 0, 1'b0, 1'b0);

    // start+stop together, single-hop frames
    run(3, 1'b0, 3, -1, 0, 1'b1, 1'b0);
    run(1, 1'b0, 3, -1, 0, 1'b0, 1'b0);
    run(1, 1'b1, 3, 3, 0, 1'b0, 1'b0);

    // num_hops = 0 ignored
    @(negedge clk);
    start    = 1'b1;
    num_hops = '0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("nh0_busy", busy, 0);
    chk("nh0_done", done, 0);

    // stop in LOAD
    @(negedge clk);
    start    = 1'b1;
    num_hops = 5'd3;
    loop_en  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b1;
    #1;
    chk("ldstop_busy", busy, 1);
    @(negedge clk);
    stop = 1'b0;
    #1;
    chk("ldstop_done", done, 1);
    chk("ldstop_busy_idle", busy, 0);

    // reset mid-RUN
    @(negedge clk);
    start    = 1'b1;
    num_hops = 5'd4;
    loop_en  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_tvalid", chip_phase_tvalid, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_vals("midrst");
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_nodone", done, 0);
    chk("midrst_idle", busy, 0);

    // randomized sessions
    repeat (25) begin
      nh  = $urandom_range(1, 16);
      lp  = 1'($urandom_range(0, 1));
      len = $urandom_range(2, 6);
      sc  = $urandom_range(0, len - 1);
      if (lp) begin
        sk = $urandom_range(0, 2 * nh);
      end else if ($urandom_range(0, 1) != 0) begin
        sk = $urandom_range(0, nh - 1);
      end else begin
        sk = -1;
      end
      if ($urandom_range(0, 3) == 0) begin
        tbl_write($urandom_range(0, 15), PW'($urandom));
      end
      run(nh, lp, len, sk, sc,
          1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef MTX_HOP_SCHED_STATS_EN
    // 2 frames of 3 hops, tready low for 4 cycles
    @(negedge clk);
    start    = 1'b1;
    num_hops = 5'd3;
    loop_en  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      chip_hop_ready    = ((c % 4) == 3);
      chip_phase_tready = !(c >= 5 && c < 9);
    end
    @(negedge clk);
    chip_hop_ready    = 1'b0;
    chip_phase_tready = 1'b1;
    #1;
    chk("stat_hops", stat_hops, 6);
    chk("stat_frames", stat_frames, 2);
    chk("stat_stall", stat_stall, 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("stat_clr", stat_hops, 0);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
